divider_data_path: RTL and testbench



---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_data_path_if.sv | 22 ++
 rtl/divider_data_path_restoring_step.sv | 28 ++
 rtl/divider_data_path.sv | 76 +++++++
 tb/tb_divider_data_path.sv | 118 +++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider controller and datapath.
// Keeping the step-select encodings here stops the two halves from diverging.
package divider_pkg;

    localparam logic [1:0] SEL_LOAD  = 2'b00;
    localparam logic [1:0] SEL_STEP  = 2'b01;
    localparam logic [1:0] SEL_LATCH = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STEP  = 2'b01,
        OP_LATCH = 2'b10,
        OP_HOLD  = 2'b11
    } sel_e;

endpackage

// File: rtl/divider_data_path_if.sv
// Operand/result bundle between the divider controller side and the datapath.
interface divider_data_path_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic [1:0]       sel;
    logic [WIDTH-1:0] n_n;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output dividend_in, divisor_in, sel,
        input  n_n, quotient, remainder, div_by_zero
    );

    modport slave (
        input  dividend_in, divisor_in, sel,
        output n_n, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_data_path_restoring_step.sv
// One restoring shift/subtract iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module restoring_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rh,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rh_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] t_s;

    assign t_s = {rh, q[WIDTH-1]};

    // Compare at WIDTH+1 bits; a fitting difference is always below d, so WIDTH bits hold it.
    always_comb begin
        rh_next = t_s[WIDTH-1:0];
        q_next  = {q[WIDTH-2:0], 1'b0};
        if (t_s >= {1'b0, d}) begin
            rh_next = t_s[WIDTH-1:0] - d;
            q_next  = {q[WIDTH-2:0], 1'b1};
        end else begin
            rh_next = t_s[WIDTH-1:0];
            q_next  = {q[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/divider_data_path.sv
// Datapath of the sequential restoring divider: working registers, iteration
// counter and the result registers that only move on LATCH.
module divider_data_path
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    divider_data_path_if.slave bus
);
    logic [WIDTH-1:0] rh_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic             z_r;
    logic [WIDTH-1:0] n_n_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;
    logic [WIDTH-1:0] rh_next_s;
    logic [WIDTH-1:0] q_next_s;

    restoring_step #(.WIDTH(WIDTH)) u_step (
        .rh      (rh_r),
        .q       (q_r),
        .d       (d_r),
        .rh_next (rh_next_s),
        .q_next  (q_next_s)
    );

    // Working registers, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rh_r          <= {WIDTH{1'b0}};
            q_r           <= {WIDTH{1'b0}};
            d_r           <= {WIDTH{1'b0}};
            z_r           <= 1'b0;
            n_n_r         <= {WIDTH{1'b0}};
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else begin
            case (bus.sel)
                SEL_LOAD: begin
                    rh_r  <= {WIDTH{1'b0}};
                    q_r   <= bus.dividend_in;
                    d_r   <= bus.divisor_in;
                    z_r   <= (bus.divisor_in == {WIDTH{1'b0}});
                    n_n_r <= WIDTH'(WIDTH);
                end
                SEL_STEP: begin
                    rh_r  <= rh_next_s;
                    q_r   <= q_next_s;
                    n_n_r <= (n_n_r == {WIDTH{1'b0}}) ? {WIDTH{1'b0}}
                                                       : n_n_r - WIDTH'(1);
                end
                SEL_LATCH: begin
                    quotient_r    <= q_r;
                    remainder_r   <= rh_r;
                    div_by_zero_r <= z_r;
                end
                SEL_HOLD: begin
                    n_n_r <= n_n_r;
                end
                default: begin
                    n_n_r <= n_n_r;
                end
            endcase
        end
    end

    assign bus.n_n         = n_n_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_divider_data_path.sv
// Directed bench for divider_data_path: drives sel sequences directly and checks
// counter, result stability and results against a scoreboard queue.
module tb_divider_data_path;
    import divider_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    result_t sb_q[$];
    result_t cur;

    divider_data_path_if #(.WIDTH(W)) bus ();

    divider_data_path #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input result_t exp);
        check({tag, ".quotient"},  bus.quotient,  exp.q);
        check({tag, ".remainder"}, bus.remainder, exp.r);
        check({tag, ".dbz"},       W'(bus.div_by_zero), W'(exp.z));
    endtask

    // Drives one cycle at the falling edge; state from the previous rising edge is visible then.
    task automatic drive(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.sel         = s;
        bus.dividend_in = a;
        bus.divisor_in  = b;
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle);
        result_t exp;
        result_t got;
        exp.q = (b == 8'd0) ? 8'hFF : a / b;
        exp.r = (b == 8'd0) ? a : a % b;
        exp.z = (b == 8'd0);
        drive(SEL_LOAD, a, b);
        for (int i = 0; i < W; i++) begin
            drive(SEL_STEP,
                  toggle ? W'($urandom_range(0, 255)) : a,
                  toggle ? W'($urandom_range(0, 255)) : b);
            check($sformatf("n_n_step%0d", i), bus.n_n, W'(W - i));
            check_outputs($sformatf("held_step%0d", i), cur);
        end
        drive(SEL_LATCH, a, b);
        check("n_n_latch", bus.n_n, 8'd0);
        check_outputs("before_latch_visible", cur);
        sb_q.push_back(exp);
        drive(SEL_HOLD, a, b);
        got = sb_q.pop_front();
        check_outputs($sformatf("result_%0d_%0d", a, b), got);
        cur = got;
        drive(SEL_HOLD, a, b);
        check_outputs("hold_stable", cur);
        check("n_n_hold", bus.n_n, 8'd0);
    endtask

    initial begin
        cur = '0;
        bus.sel = SEL_HOLD;
        bus.dividend_in = 8'd0;
        bus.divisor_in  = 8'd0;
        rst = 1'b1;
        drive(SEL_LOAD, 8'd11, 8'd3);
        drive(SEL_LOAD, 8'd11, 8'd3);
        check_outputs("reset", cur);
        check("reset_n_n", bus.n_n, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(8'd100, 8'd7, 1'b0);
        run_div(8'd255, 8'd1, 1'b0);
        run_div(8'd5,   8'd9, 1'b0);
        run_div(8'd37,  8'd0, 1'b0);

        // Abort 200/3 on its fourth step.
        drive(SEL_LOAD, 8'd200, 8'd3);
        for (int i = 0; i < 3; i++) drive(SEL_STEP, 8'd200, 8'd3);
        drive(SEL_STEP, 8'd200, 8'd3);
        rst = 1'b1;
        drive(SEL_HOLD, 8'd200, 8'd3);
        rst = 1'b0;
        cur = '0;
        check_outputs("mid_reset", cur);
        check("mid_reset_n_n", bus.n_n, 8'd0);
        run_div(8'd200, 8'd3, 1'b0);

        // Back-to-back with operand inputs churning during the steps.
        run_div(8'd100, 8'd7, 1'b0);
        run_div(8'd50,  8'd6, 1'b1);

        check("scoreboard_empty", W'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
